inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/riscv_enc_pkg.sv | 39 +++
 rtl/imm_range_check.sv | 35 +++
 rtl/inst_encoder.sv | 109 ++++++++++
 tb/tb_inst_encoder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared definitions for the RISC-V instruction encoder: format codes,
// base opcodes and the immediate ranges each format can represent.
package riscv_enc_pkg;

  // Instruction format selector. Codes 6 and 7 are unassigned and illegal.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // RV32I base opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;

  // Immediate ranges. B and J offsets must additionally be even.
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX =  32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX =  32'sd4094;
  localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX =  32'sd1048574;

  // True for the six defined format codes.
  function automatic logic fmt_is_legal(input logic [2:0] f);
    return (f <= 3'd5);
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational legality check: flags an immediate that the selected
// format cannot represent exactly, or a format code that does not exist.
module imm_range_check
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic        err
);

  logic signed [31:0] simm;
  logic               in_12;
  logic               in_b;
  logic               in_j;

  assign simm  = $signed(imm);
  assign in_12 = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
  assign in_b  = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX);
  assign in_j  = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX);

  // Per-format legality; R ignores the immediate entirely.
  always_comb begin
    err = 1'b0;
    case (fmt)
      FMT_R:   err = 1'b0;
      FMT_I:   err = !in_12;
      FMT_S:   err = !in_12;
      FMT_B:   err = !in_b || imm[0];
      FMT_U:   err = (imm[11:0] != 12'h000);
      FMT_J:   err = !in_j || imm[0];
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32 instruction encoder with a one-entry valid/ready output register.
//
// Handshake: a request is taken on a rising edge where in_valid && in_ready;
// in_ready = !out_valid || out_ready, so a word leaving and a new one
// arriving in the same cycle sustains one word per cycle. The output word,
// its error flag and out_valid stay frozen while out_valid && !out_ready.
module inst_encoder
  import riscv_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        imm_err,
  output logic [15:0] enc_cnt,
  output logic [15:0] err_cnt
);

  logic        accept;
  logic        range_err;
  logic [31:0] packed_word;

  logic [31:0] inst_d,      inst_q;
  logic        imm_err_d,   imm_err_q;
  logic        out_valid_d, out_valid_q;
  logic [15:0] enc_cnt_d,   enc_cnt_q;
  logic [15:0] err_cnt_d,   err_cnt_q;

  imm_range_check u_range (
    .fmt (fmt),
    .imm (imm),
    .err (range_err)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Bit packing per format; out-of-range immediates are simply truncated,
  // the error flag comes from the range checker. Illegal formats give zero.
  always_comb begin
    packed_word = 32'h0000_0000;
    case (fmt)
      FMT_R: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: packed_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: packed_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
      FMT_U: packed_word = {imm[31:12], rd, opcode};
      FMT_J: packed_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                            rd, opcode};
      default: packed_word = 32'h0000_0000;
    endcase
  end

  // Next-state: load on accept, drain on pop, otherwise hold.
  always_comb begin
    inst_d      = inst_q;
    imm_err_d   = imm_err_q;
    out_valid_d = out_valid_q;
    enc_cnt_d   = enc_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      inst_d      = fmt_is_legal(fmt) ? packed_word : 32'h0000_0000;
      imm_err_d   = range_err;
      out_valid_d = 1'b1;
      enc_cnt_d   = enc_cnt_q + 16'd1;
      if (range_err) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= 32'h0000_0000;
      imm_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      enc_cnt_q   <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      inst_q      <= inst_d;
      imm_err_q   <= imm_err_d;
      out_valid_q <= out_valid_d;
      enc_cnt_q   <= enc_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign inst      = inst_q;
  assign imm_err   = imm_err_q;
  assign out_valid = out_valid_q;
  assign enc_cnt   = enc_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed literal vectors, backpressure, reset
// pulse and a random round-trip phase against a behavioural model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [31:0] imm = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic        imm_err;
  logic [31:0] inst;
  logic [15:0] enc_cnt;
  logic [15:0] err_cnt;

  int total = 0;
  int bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  inst_encoder u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .imm_err   (imm_err),
    .enc_cnt   (enc_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic m_legal(input logic [2:0] f, input logic [31:0] v);
    int signed s;
    s = $signed(v);
    case (f)
      3'd0:    return 1'b1;
      3'd1:    return (s >= -2048) && (s <= 2047);
      3'd2:    return (s >= -2048) && (s <= 2047);
      3'd3:    return (s >= -4096) && (s <= 4094) && (v[0] == 1'b0);
      3'd4:    return (v[11:0] == 12'd0);
      3'd5:    return (s >= -1048576) && (s <= 1048574) && (v[0] == 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_encode(input logic [2:0] f, input logic [6:0] opc,
                                           input logic [4:0] rdv, input logic [4:0] r1,
                                           input logic [4:0] r2, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] v);
    logic [31:0] base;
    base = 32'(opc) | (32'(f3) << 12) | (32'(r1) << 15);
    case (f)
      3'd0: return base | (32'(rdv) << 7) | (32'(r2) << 20) | (32'(f7) << 25);
      3'd1: return base | (32'(rdv) << 7) | ((v & 32'hFFF) << 20);
      3'd2: return base | (32'(r2) << 20) | ((v & 32'h1F) << 7) | (((v >> 5) & 32'h7F) << 25);
      3'd3: return base | (32'(r2) << 20) | (((v >> 1) & 32'hF) << 8)
                 | (((v >> 11) & 32'd1) << 7) | (((v >> 5) & 32'h3F) << 25)
                 | (((v >> 12) & 32'd1) << 31);
      3'd4: return (v & 32'hFFFFF000) | (32'(rdv) << 7) | 32'(opc);
      3'd5: return 32'(opc) | (32'(rdv) << 7) | (((v >> 12) & 32'hFF) << 12)
                 | (((v >> 11) & 32'd1) << 20) | (((v >> 1) & 32'h3FF) << 21)
                 | (((v >> 20) & 32'd1) << 31);
      default: return 32'd0;
    endcase
  endfunction

  // Pull the immediate back out of an encoded word.
  function automatic logic [31:0] m_decode(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd1:    return {{20{w[31]}}, w[31:20]};
      3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    return {w[31:12], 12'd0};
      3'd5:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  logic        m_valid = 1'b0;
  logic [31:0] m_inst = 32'd0;
  logic        m_err = 1'b0;
  logic [2:0]  m_fmt = 3'd0;
  logic [31:0] m_imm = 32'd0;
  logic [15:0] m_enc = 16'd0;
  logic [15:0] m_errc = 16'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_inst = 32'd0; m_err = 1'b0;
      m_enc = 16'd0;  m_errc = 16'd0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid = 1'b1;
      m_fmt   = fmt;
      m_imm   = imm;
      m_err   = !m_legal(fmt, imm);
      m_inst  = m_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
      m_enc   = m_enc + 16'd1;
      if (m_err) m_errc = m_errc + 16'd1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      if (m_valid) begin
        check("inst", inst, m_inst);
        check("imm_err", 32'(imm_err), 32'(m_err));
        if (!m_err && m_fmt != 3'd0)
          check("roundtrip", m_decode(m_fmt, inst), m_imm);
      end
      check("enc_cnt", 32'(enc_cnt), 32'(m_enc));
      check("err_cnt", 32'(err_cnt), 32'(m_errc));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_fields(input logic [2:0] f, input logic [6:0] opc, input logic [4:0] rdv,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] v);
    fmt = f; opcode = opc; rd = rdv; rs1 = r1; rs2 = r2;
    funct3 = f3; funct7 = f7; imm = v;
  endtask

  // Called at posedge+1: presents one request with out_ready=1, checks literals.
  task automatic req(input string name, input logic [2:0] f, input logic [6:0] opc,
                     input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] v,
                     input logic [31:0] exp_inst, input logic exp_err);
    set_fields(f, opc, rdv, r1, r2, f3, f7, v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check(name, inst, exp_inst);
    check({name, "_err"}, 32'(imm_err), 32'(exp_err));
  endtask

  task automatic rand_fields();
    logic [2:0]  f;
    logic [31:0] v;
    f = 3'($urandom_range(0, 5));
    if ($urandom_range(0, 15) == 0) f = 3'($urandom_range(6, 7));
    case (f)
      3'd1, 3'd2: v = 32'(int'($urandom_range(0, 4095)) - 2048);
      3'd3:       v = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      3'd4:       v = $urandom & 32'hFFFFF000;
      3'd5:       v = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
      default:    v = $urandom;
    endcase
    if ($urandom_range(0, 7) == 0) v = $urandom;
    set_fields(f, 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_imm_err", 32'(imm_err), 32'd0);
    check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Directed encodings with hand-computed words.
    req("i_addi",  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00500093, 1'b0);
    req("s_sw",    3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020A423, 1'b0);
    req("b_beq",   3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC,   32'hFE000EE3, 1'b0);
    req("u_lui",   3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,   32'h123452B7, 1'b0);
    req("j_jal",   3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,          32'h0000006F, 1'b0);
    req("r_add",   3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF,   32'h002081B3, 1'b0);
    check("err_cnt_before", 32'(err_cnt), 32'd0);
    req("i_2048",  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h80000093, 1'b1);
    check("err_cnt_inc", 32'(err_cnt), 32'd1);
    req("b_odd",   3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,          32'h00000163, 1'b1);
    req("fmt7",    3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00000000, 1'b1);
    req("fmt6",    3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00000000, 1'b1);
    req("i_min",   3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800,   32'h80000093, 1'b0);
    req("j_max",   3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574,    32'h7FFFF06F, 1'b0);
    req("b_max",   3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,       32'h7E000FE3, 1'b0);
    req("u_low",   3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001,   32'h123452B7, 1'b1);
    check("enc_cnt_dir", 32'(enc_cnt), 32'd14);
    check("err_cnt_dir", 32'(err_cnt), 32'd5);

    // Drain, then backpressure for 3 cycles.
    @(posedge clk); #1;
    set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    imm = 32'd7;
    for (int i = 0; i < 3; i++) begin
      check("bp_inst", inst, 32'h00500093);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      imm = 32'(k);
      @(posedge clk); #1;
      check("stream_inst", inst, (32'(k) << 20) | 32'h93);
    end
    check("stream_cnt", 32'(enc_cnt), 32'd19);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset pulse with a word pending.
    set_fields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_inst", inst, 32'd0);
    check("arst_err", 32'(imm_err), 32'd0);
    check("arst_enc", 32'(enc_cnt), 32'd0);
    check("arst_errc", 32'(err_cnt), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Random traffic; the compare process checks every cycle.
    for (int n = 0; n < 400; n++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
